// File: rtl/ysyx_25040109_mem_arbiter.sv
// Two-master, one-slave memory arbiter: round-robin grant, one outstanding
// transaction, combinational response path and a response watchdog.
module ysyx_25040109_mem_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_ren,
    input  logic [31:0] m0_raddr,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    output logic [31:0] m0_rdata,
    input  logic        m1_ren,
    input  logic [31:0] m1_raddr,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    output logic [31:0] m1_rdata,
    input  logic        m1_wvalid,
    input  logic [31:0] m1_waddr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_wlen,
    output logic        m1_wready,
    output logic        s_req_valid,
    input  logic        s_req_ready,
    output logic        s_req_wen,
    output logic [31:0] s_req_addr,
    output logic [31:0] s_req_wdata,
    output logic [2:0]  s_req_wlen,
    input  logic        s_resp_valid,
    output logic        s_resp_ready,
    input  logic [31:0] s_resp_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned LW    = 3;
    localparam int unsigned CW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic        WD_EN = (TIMEOUT != 32'd0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_last_m1;
    logic [1:0]      r_grant;
    logic            r_req_valid;
    logic            r_wen;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [LW-1:0]   r_wlen;
    logic [CW-1:0]   r_cnt;
    logic            r_timeout_err;

    logic            w_m0_cand;
    logic            w_m1_cand;
    logic            w_pick_m1;
    logic            w_in_resp;
    logic            w_to;
    logic            w_rd_rdy;
    logic            w_rd_phase;
    logic            w_rvalid;
    logic [DW-1:0]   w_rdata;
    logic            w_done;
    logic [CW-1:0]   w_cnt_inc;

    // Arbitration: a tie goes to the master that did not win last time
    assign w_m0_cand = m0_ren;
    assign w_m1_cand = m1_ren | m1_wvalid;
    assign w_pick_m1 = w_m1_cand & (~w_m0_cand | ~r_last_m1);

    // Response path: watchdog expiry substitutes ERR_DATA and blocks the slave
    assign w_in_resp  = (r_state == S_RESP);
    assign w_to       = w_in_resp & WD_EN & (r_cnt == CW'(TIMEOUT));
    assign w_rd_rdy   = r_grant[0] ? m0_rready : m1_rready;
    assign w_rd_phase = w_in_resp & ~r_wen;
    assign w_rvalid   = w_rd_phase & (w_to | s_resp_valid);
    assign w_rdata    = w_to ? ERR_DATA : s_resp_rdata;
    assign w_done     = w_to ? (r_wen | w_rd_rdy)
                             : (s_resp_valid & (r_wen | w_rd_rdy));
    assign w_cnt_inc  = r_cnt + CW'(1);

    assign s_resp_ready = w_in_resp & ~w_to & (r_wen | w_rd_rdy);
    assign m0_rvalid    = w_rvalid & r_grant[0];
    assign m1_rvalid    = w_rvalid & r_grant[1];
    assign m0_rdata     = (w_rd_phase & r_grant[0]) ? w_rdata : '0;
    assign m1_rdata     = (w_rd_phase & r_grant[1]) ? w_rdata : '0;
    assign m1_wready    = w_in_resp & r_wen & (w_to | s_resp_valid);

    assign s_req_valid  = r_req_valid;
    assign s_req_wen    = r_wen;
    assign s_req_addr   = r_addr;
    assign s_req_wdata  = r_wdata;
    assign s_req_wlen   = r_wlen;
    assign grant        = r_grant;
    assign timeout_err  = r_timeout_err;

    // Transaction FSM with latched request fields and watchdog counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_last_m1     <= 1'b0;
            r_grant       <= 2'b00;
            r_req_valid   <= 1'b0;
            r_wen         <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_wlen        <= '0;
            r_cnt         <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_m0_cand | w_m1_cand) begin
                        r_state     <= S_REQ;
                        r_req_valid <= 1'b1;
                        r_last_m1   <= w_pick_m1;
                        if (w_pick_m1) begin
                            r_grant <= 2'b10;
                            r_wen   <= m1_wvalid;
                            r_addr  <= m1_wvalid ? m1_waddr : m1_raddr;
                            r_wdata <= m1_wvalid ? m1_wdata : '0;
                            r_wlen  <= m1_wvalid ? m1_wlen  : '0;
                        end else begin
                            r_grant <= 2'b01;
                            r_wen   <= 1'b0;
                            r_addr  <= m0_raddr;
                            r_wdata <= '0;
                            r_wlen  <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (s_req_ready) begin
                        r_state     <= S_RESP;
                        r_req_valid <= 1'b0;
                        r_cnt       <= '0;
                    end
                end
                S_RESP: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                        r_grant <= 2'b00;
                    end else if (!s_resp_valid && WD_EN && !w_to) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == CW'(TIMEOUT)) begin
                            r_timeout_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040109_mem_arbiter.sv
// Directed self-checking bench for the two-master memory arbiter.
module tb_ysyx_25040109_mem_arbiter;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        rst_n;
    logic        m0_ren, m0_rready, m0_rvalid;
    logic [31:0] m0_raddr, m0_rdata;
    logic        m1_ren, m1_rready, m1_rvalid;
    logic [31:0] m1_raddr, m1_rdata;
    logic        m1_wvalid, m1_wready;
    logic [31:0] m1_waddr, m1_wdata;
    logic [2:0]  m1_wlen;
    logic        s_req_valid, s_req_ready, s_req_wen;
    logic [31:0] s_req_addr, s_req_wdata;
    logic [2:0]  s_req_wlen;
    logic        s_resp_valid, s_resp_ready;
    logic [31:0] s_resp_rdata;
    logic [1:0]  grant;
    logic        timeout_err;

    int n_cmp = 0;
    int n_mis = 0;

    ysyx_25040109_mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .m0_ren(m0_ren), .m0_raddr(m0_raddr), .m0_rvalid(m0_rvalid),
        .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m1_ren(m1_ren), .m1_raddr(m1_raddr), .m1_rvalid(m1_rvalid),
        .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .m1_wvalid(m1_wvalid), .m1_waddr(m1_waddr), .m1_wdata(m1_wdata),
        .m1_wlen(m1_wlen), .m1_wready(m1_wready),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_wen(s_req_wen),
        .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata), .s_req_wlen(s_req_wlen),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
        .s_resp_rdata(s_resp_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        m0_ren = 0; m0_raddr = '0; m0_rready = 0;
        m1_ren = 0; m1_raddr = '0; m1_rready = 0;
        m1_wvalid = 0; m1_waddr = '0; m1_wdata = '0; m1_wlen = '0;
        s_req_ready = 0; s_resp_valid = 0; s_resp_rdata = '0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        do_reset();

        // Reset values, with a stray slave response that must be ignored
        s_resp_valid = 1; s_resp_rdata = 32'h55AA55AA;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_req_valid", 32'(s_req_valid), 32'd0);
        check("rst_req_addr", s_req_addr, 32'd0);
        check("rst_resp_ready", 32'(s_resp_ready), 32'd0);
        check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        s_resp_valid = 0;

        // Single m0 read, zero-wait slave
        m0_ren = 1; m0_raddr = 32'h80000000; m0_rready = 1; s_req_ready = 1;
        adv(); s_resp_valid = 1; s_resp_rdata = 32'h00000413; mid();
        check("t1_req_valid", 32'(s_req_valid), 32'd1);
        check("t1_req_addr", s_req_addr, 32'h80000000);
        check("t1_req_wen", 32'(s_req_wen), 32'd0);
        check("t1_grant_req", 32'(grant), 32'd1);
        check("t1_resp_ready_req", 32'(s_resp_ready), 32'd0);
        check("t1_rvalid_req", 32'(m0_rvalid), 32'd0);
        adv(); mid();
        check("t1_rvalid", 32'(m0_rvalid), 32'd1);
        check("t1_rdata", m0_rdata, 32'h00000413);
        check("t1_grant_resp", 32'(grant), 32'd1);
        check("t1_m1_rvalid", 32'(m1_rvalid), 32'd0);
        check("t1_req_valid_resp", 32'(s_req_valid), 32'd0);
        adv(); m0_ren = 0; s_resp_valid = 0; mid();
        check("t1_grant_idle", 32'(grant), 32'd0);

        // Back-to-back ties from reset: m1, m0, m1, m0
        do_reset();
        m0_ren = 1; m0_raddr = 32'h80000100; m0_rready = 1;
        m1_ren = 1; m1_raddr = 32'h80000200; m1_rready = 1;
        s_req_ready = 1; s_resp_valid = 1;
        for (int k = 0; k < 4; k++) begin
            logic is_m1;
            is_m1 = (k % 2) == 0;
            s_resp_rdata = 32'hA5A50000 + 32'(k);
            adv(); mid();
            check("t2_grant", 32'(grant), is_m1 ? 32'd2 : 32'd1);
            check("t2_addr", s_req_addr, is_m1 ? 32'h80000200 : 32'h80000100);
            check("t2_resp_ready_req", 32'(s_resp_ready), 32'd0);
            adv(); mid();
            check("t2_rvalid", {30'd0, m1_rvalid, m0_rvalid}, is_m1 ? 32'd2 : 32'd1);
            check("t2_rdata", is_m1 ? m1_rdata : m0_rdata, 32'hA5A50000 + 32'(k));
            check("t2_other_rdata", is_m1 ? m0_rdata : m1_rdata, 32'd0);
            adv(); mid();
            check("t2_grant_idle", 32'(grant), 32'd0);
        end
        m0_ren = 0; m1_ren = 0; s_resp_valid = 0;

        // m1 store acked on the third RESP cycle; pending m1 read follows
        m1_wvalid = 1; m1_waddr = 32'h80001000; m1_wdata = 32'h12345678; m1_wlen = 3'd4;
        m1_ren = 1; m1_raddr = 32'h80001004; m1_rready = 1; s_req_ready = 1;
        adv(); mid();
        check("t3_req_valid", 32'(s_req_valid), 32'd1);
        check("t3_wen", 32'(s_req_wen), 32'd1);
        check("t3_addr", s_req_addr, 32'h80001000);
        check("t3_wdata", s_req_wdata, 32'h12345678);
        check("t3_wlen", 32'(s_req_wlen), 32'd4);
        check("t3_grant", 32'(grant), 32'd2);
        for (int c = 0; c < 2; c++) begin
            adv(); mid();
            check("t3_wready_wait", 32'(m1_wready), 32'd0);
            check("t3_resp_ready", 32'(s_resp_ready), 32'd1);
        end
        adv(); s_resp_valid = 1; mid();
        check("t3_wready_ack", 32'(m1_wready), 32'd1);
        check("t3_no_rvalid", 32'(m1_rvalid), 32'd0);
        adv(); m1_wvalid = 0; s_resp_valid = 0; mid();
        check("t3_wready_after", 32'(m1_wready), 32'd0);
        check("t3_grant_idle", 32'(grant), 32'd0);
        adv(); mid();
        check("t3_rd_wen", 32'(s_req_wen), 32'd0);
        check("t3_rd_addr", s_req_addr, 32'h80001004);
        adv(); s_resp_valid = 1; s_resp_rdata = 32'hCAFE0001; mid();
        check("t3_rd_rvalid", 32'(m1_rvalid), 32'd1);
        check("t3_rd_rdata", m1_rdata, 32'hCAFE0001);
        adv(); m1_ren = 0; s_resp_valid = 0; mid();
        check("t3_rd_idle", 32'(grant), 32'd0);

        // m1 read with rready held low for two cycles
        m1_ren = 1; m1_raddr = 32'h80002000; m1_rready = 0; s_req_ready = 1;
        adv(); mid();
        adv(); s_resp_valid = 1; s_resp_rdata = 32'h0BADF00D; mid();
        check("t4_resp_ready_lo1", 32'(s_resp_ready), 32'd0);
        check("t4_rvalid1", 32'(m1_rvalid), 32'd1);
        adv(); mid();
        check("t4_resp_ready_lo2", 32'(s_resp_ready), 32'd0);
        check("t4_grant_held", 32'(grant), 32'd2);
        adv(); m1_rready = 1; mid();
        check("t4_resp_ready_hi", 32'(s_resp_ready), 32'd1);
        check("t4_rdata", m1_rdata, 32'h0BADF00D);
        check("t4_m0_rvalid", 32'(m0_rvalid), 32'd0);
        adv(); m1_ren = 0; m1_rready = 0; s_resp_valid = 0; mid();
        check("t4_grant_idle", 32'(grant), 32'd0);

        // Watchdog on an m0 read that the slave never answers
        m0_ren = 1; m0_raddr = 32'h80003000; m0_rready = 0; s_req_ready = 1;
        adv(); mid();
        for (int c = 0; c < int'(TO); c++) begin
            adv(); mid();
            check("t5_err_early", 32'(timeout_err), 32'd0);
            check("t5_rvalid_early", 32'(m0_rvalid), 32'd0);
        end
        adv(); mid();
        check("t5_err", 32'(timeout_err), 32'd1);
        check("t5_rvalid", 32'(m0_rvalid), 32'd1);
        check("t5_rdata", m0_rdata, 32'hDEADBEEF);
        check("t5_resp_ready", 32'(s_resp_ready), 32'd0);
        adv(); mid();
        check("t5_rvalid_hold", 32'(m0_rvalid), 32'd1);
        adv(); m0_rready = 1; mid();
        check("t5_rvalid_hs", 32'(m0_rvalid), 32'd1);
        adv(); m0_ren = 0; m0_rready = 0; s_resp_valid = 1; s_resp_rdata = 32'h77777777; mid();
        check("t5_grant_idle", 32'(grant), 32'd0);
        check("t5_late_rvalid", 32'(m0_rvalid), 32'd0);
        check("t5_late_ready", 32'(s_resp_ready), 32'd0);
        check("t5_err_sticky", 32'(timeout_err), 32'd1);
        s_resp_valid = 0;

        // Asynchronous reset mid-RESP, then first tie goes to m1
        m0_ren = 1; m0_raddr = 32'h80004000; m1_ren = 1; m1_raddr = 32'h80005000;
        s_req_ready = 1;
        adv(); mid();
        check("t6_grant_req", 32'(grant), 32'd2);
        adv(); s_resp_valid = 1; s_resp_rdata = 32'h11112222; mid();
        check("t6_rvalid_pre", 32'(m1_rvalid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_grant_rst", 32'(grant), 32'd0);
        check("t6_rvalid_rst", 32'(m1_rvalid), 32'd0);
        check("t6_rdata_rst", m1_rdata, 32'd0);
        check("t6_resp_ready_rst", 32'(s_resp_ready), 32'd0);
        check("t6_req_addr_rst", s_req_addr, 32'd0);
        check("t6_err_rst", 32'(timeout_err), 32'd0);
        s_resp_valid = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        adv(); mid();
        check("t6_grant_after", 32'(grant), 32'd2);
        check("t6_addr_after", s_req_addr, 32'h80005000);
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ysyx_25040109_mem_arbiter.md
# ysyx_25040109_mem_arbiter

Two-master, one-slave memory arbiter that shares a single memory port between the instruction-fetch channel (master 0, read-only) and the load/store channel (master 1, read and write). It sits between the CPU's imem/dmem handshake ports and the memory model. It serialises transactions with one outstanding request at a time, round-robin arbitration and a response timeout watchdog.

## Interface
- TIMEOUT, 255: cycles allowed in RESP before the watchdog fires; 0 disables the watchdog.
- ERR_DATA, 32'hDEADBEEF: read data returned on a timeout.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low, synchronous release.
- m0_ren  in  1  fetch read request valid; master holds it until m0_rvalid&&m0_rready.
- m0_raddr  in  32  fetch address.
- m0_rvalid  out  1  fetch read data valid.
- m0_rready  in  1  fetch master accepts data.
- m0_rdata  out  32  fetch read data.
- m1_ren  in  1  load request valid; held until complete.
- m1_raddr  in  32  load address.
- m1_rvalid  out  1  load data valid.
- m1_rready  in  1  load master accepts data.
- m1_rdata  out  32  load data.
- m1_wvalid  in  1  store request valid; held until m1_wready.
- m1_waddr  in  32  store address.
- m1_wdata  in  32  store data.
- m1_wlen  in  3  store byte length code, passed through unchanged.
- m1_wready  out  1  one-cycle store completion pulse.
- s_req_valid  out  1  slave request valid.
- s_req_ready  in  1  slave accepts request.
- s_req_wen  out  1  1 = write, 0 = read.
- s_req_addr  out  32  latched address.
- s_req_wdata  out  32  latched store data.
- s_req_wlen  out  3  latched store length.
- s_resp_valid  in  1  slave response valid (read data or write acknowledge).
- s_resp_ready  out  1  arbiter accepts response.
- s_resp_rdata  in  32  slave read data.
- grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1; 0 when IDLE.
- timeout_err  out  1  sticky watchdog flag, cleared only by reset.

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE
  - Candidates are m0 (m0_ren) and m1 (m1_ren||m1_wvalid).
  - One candidate: grant it.
  - Both candidates: grant the master that is not last_grant. last_grant resets to m0, so the first tie goes to m1.
  - On grant, latch the address, wdata, wlen and wen, update last_grant, and go to REQ.
  - m1 with both m1_wvalid and m1_ren: the write is selected; the read stays pending.
- REQ
  - s_req_valid=1 with the latched fields.
  - On s_req_ready, go to RESP and clear the watchdog counter.
  - Master inputs are ignored while in REQ; only the latched copy is used.
- RESP, read
  - s_resp_ready = granted master's rready.
  - Granted m*_rvalid = s_resp_valid.
  - Granted m*_rdata = s_resp_rdata.
  - When s_resp_valid&&s_resp_ready, go to IDLE.
- RESP, write
  - s_resp_ready=1.
  - m1_wready = s_resp_valid.
  - Go to IDLE on that cycle.
- Watchdog
  - The counter increments each cycle in RESP without s_resp_valid.
  - When the counter equals TIMEOUT (and TIMEOUT≠0), set timeout_err.
  - Read timeout: present ERR_DATA as a response to the master, with m*_rvalid forced to 1 until rready.
  - Write timeout: pulse m1_wready.
  - Then return to IDLE.
  - A late slave response is not forwarded to either master.
- Non-granted master outputs: rvalid=0, rdata=0, wready=0.

## Timing
- Reset values: all valids and ready outputs 0, rdata 0, s_req_* 0, grant 0, timeout_err 0, state IDLE, last_grant m0, counter 0.
- Registered outputs: s_req_* and grant. The response path master↔slave is combinational.
- Minimum latency, with the request seen in IDLE at cycle T:
  - s_req_valid at T+1.
  - With s_req_ready at T+1, RESP at T+2.
  - A zero-wait response completes at T+2.
  - The next grant is possible at T+3.
- Back-to-back ties alternate strictly between m0 and m1.
- Asynchronous reset in REQ or RESP: all outputs drop to reset values immediately. The in-flight transaction is abandoned, with no response to any master.
- s_resp_valid arriving in IDLE or REQ is ignored; s_resp_ready=0 in those states.

## Test plan
- m0 read of 0x80000000 only, slave ready immediately, rdata 0x00000413 -> s_req_valid at T+1 with addr 0x80000000, wen=0; m0_rvalid=1 with rdata 0x00000413 at T+2; grant=01 during T+1..T+2.
- m0_ren and m1_ren both asserted from reset -> m1 is granted first (grant=10), then m0; over 4 repeated tie transactions the grant order is m1,m0,m1,m0.
- m1 store 0x12345678 to 0x80001000, wlen=4, slave acks after 3 cycles -> s_req_wen=1 with the latched fields; m1_wready is high for exactly one cycle, the ack cycle.
- m1 read with m1_rready held low for 2 cycles while s_resp_valid=1 -> s_resp_ready stays 0; completion happens on the cycle m1_rready rises; data is unchanged.
- TIMEOUT=4 and the slave never responds to an m0 read -> timeout_err=1 after 4 RESP cycles; m0_rdata=0xDEADBEEF, m0_rvalid=1; back in IDLE after the handshake.
- rst_n pulsed low mid-RESP -> all outputs 0 asynchronously, grant=00; after release, the first tie goes to m1.
